// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared types and constants for the multi-cycle integer divider.
package div_unit_pkg;
  localparam int DIV_DATA_W = 32;
  localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;
endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: EX-stage request/result bundle between the pipeline and the divider.
interface div_unit_if import div_unit_pkg::*; #(parameter int DATA_W = DIV_DATA_W) ();
  logic              start_i;
  logic              signed_i;
  logic [DATA_W-1:0] dividend_i;
  logic [DATA_W-1:0] divisor_i;
  logic              cancel_i;
  logic              ok_o;
  logic [DATA_W-1:0] quotient_o;
  logic [DATA_W-1:0] remainder_o;
  logic              busy_o;
  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i, cancel_i,
    output ok_o, quotient_o, remainder_o, busy_o
  );
  modport master (
    output start_i, signed_i, dividend_i, divisor_i, cancel_i,
    input  ok_o, quotient_o, remainder_o, busy_o
  );
endinterface

// File: rtl/div_unit_step.sv
// div_unit_step: one restoring-division iteration on {rem, quo}.
module div_unit_step #(parameter int DATA_W = 32) (
  input  logic [DATA_W:0]   rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] dvs_i,
  output logic [DATA_W:0]   rem_o,
  output logic [DATA_W-1:0] quo_o
);
  logic [DATA_W:0] sh, trial;
  assign sh    = {rem_i[DATA_W-1:0], quo_i[DATA_W-1]};
  // the extra top bit of trial is the borrow: set means the divisor did not fit
  assign trial = sh - {1'b0, dvs_i};
  assign rem_o = trial[DATA_W] ? sh : trial;
  assign quo_o = {quo_i[DATA_W-2:0], ~trial[DATA_W]};
endmodule

// File: rtl/div_unit.sv
// div_unit: radix-2 restoring DIV/DIVU for EX; holds ok_o low while a division is in flight.
module div_unit import div_unit_pkg::*; #(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input logic       clk,
  input logic       resetn,
  div_unit_if.slave bus
);
  div_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W:0]   rem_q, rem_d, step_rem;
  logic [DATA_W-1:0] quo_q, quo_d, step_quo;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [DATA_W-1:0] res_quo_q, res_quo_d, res_rem_q, res_rem_d;
  logic              neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic              dd_neg, dv_neg;
  logic [DATA_W-1:0] dd_abs, dv_abs;

  assign dd_neg = bus.signed_i & bus.dividend_i[DATA_W-1];
  assign dv_neg = bus.signed_i & bus.divisor_i[DATA_W-1];
  assign dd_abs = dd_neg ? -bus.dividend_i : bus.dividend_i;
  assign dv_abs = dv_neg ? -bus.divisor_i : bus.divisor_i;

  div_unit_step #(.DATA_W(DATA_W)) u_step (
    .rem_i(rem_q), .quo_i(quo_q), .dvs_i(dvs_q), .rem_o(step_rem), .quo_o(step_quo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    res_quo_d = res_quo_q;
    res_rem_d = res_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (bus.cancel_i) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        DIV_IDLE: if (bus.start_i) begin
          quo_d     = dd_abs;
          dvs_d     = dv_abs;
          rem_d     = '0;
          cnt_d     = '0;
          neg_quo_d = dd_neg ^ dv_neg;
          neg_rem_d = dd_neg;
          if (bus.divisor_i == '0) begin
            state_d   = DIV_DONE;
            res_quo_d = DATA_W'(DIV_ZERO_QUO);
            res_rem_d = bus.dividend_i;
          end else begin
            state_d = DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W-1)) begin
            state_d   = DIV_DONE;
            res_quo_d = neg_quo_q ? -step_quo : step_quo;
            res_rem_d = neg_rem_q ? -step_rem[DATA_W-1:0] : step_rem[DATA_W-1:0];
          end
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      res_quo_q <= '0;
      res_rem_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      res_quo_q <= res_quo_d;
      res_rem_q <= res_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign bus.ok_o        = bus.cancel_i | (state_q == DIV_IDLE & ~bus.start_i) | (state_q == DIV_DONE);
  assign bus.busy_o      = state_q == DIV_BUSY;
  assign bus.quotient_o  = res_quo_q;
  assign bus.remainder_o = res_rem_q;

  a_start_held: assert property (@(posedge clk) disable iff (!resetn)
    (state_q == DIV_BUSY) |-> (bus.start_i || bus.cancel_i));
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider in the EX stage of the 5-stage MIPS pipeline.
- Executes DIV/DIVU using radix-2 restoring division, one quotient bit per cycle.
- Drives ex_ok_i of the stall controller: low while a division is in flight, which freezes the whole pipeline.
- Results feed the HI/LO write path in EX/MEM: remainder to HI, quotient to LO.

Parameters:
DATA_W, 32, operand and result width
CNT_W, $clog2(DATA_W), iteration counter width

Ports:
clk  in  1  pipeline clock, rising edge
resetn  in  1  asynchronous active-low reset
start_i  in  1  EX holds a DIV/DIVU; level, stays high while stalled
signed_i  in  1  1 = DIV (signed), 0 = DIVU
dividend_i  in  DATA_W  rs operand
divisor_i  in  DATA_W  rt operand
cancel_i  in  1  flush/exception; aborts any division in progress
ok_o  in→out  1  to stall controller ex_ok_i; 0 = stall the pipeline
quotient_o  out  DATA_W  LO result; valid when ok_o & state DONE
remainder_o  out  DATA_W  HI result; valid when ok_o & state DONE
busy_o  out  1  state == BUSY (debug/perf counter)

Behaviour:
- Reset: state IDLE, counter 0, quotient_o 0, remainder_o 0, busy_o 0. ok_o = 1 unless start_i is high.
- States are IDLE, BUSY and DONE (div_state_t).
- ok_o is combinational:
  - 1 if cancel_i.
  - Otherwise 1 if (IDLE & ~start_i) or DONE.
  - Otherwise 0, including the IDLE cycle in which start_i rises.
- IDLE with start_i & ~cancel_i:
  - Latch |dividend| and |divisor| (abs only when signed_i).
  - Latch sign_q = signed_i & (dividend[31] ^ divisor[31]) and sign_r = signed_i & dividend[31].
  - Clear the partial remainder and set counter = 0.
  - If divisor_i == 0, go to DONE with quotient 32'hFFFF_FFFF and remainder = dividend_i raw. Latency is 1 cycle.
  - Otherwise go to BUSY.
- BUSY:
  - Each cycle: shift {rem, quo} left 1; trial = rem_hi − divisor. If trial is non-negative, rem_hi = trial and quo[0] = 1.
  - counter increments each cycle.
  - When counter == DATA_W−1: apply sign fix-up (negate quotient if sign_q, negate remainder if sign_r), register the results and go to DONE.
- Total latency: start edge in cycle 0, BUSY for cycles 1..32, DONE in cycle 33 with ok_o = 1. The pipeline advances on that edge.
- DONE:
  - Results are held stable.
  - The next state is unconditionally IDLE. A back-to-back DIV entering EX next cycle starts fresh from IDLE.
- Arithmetic:
  - Magnitude of −2^31 is 32'h8000_0000, treated as unsigned.
  - 0x8000_0000 / −1 signed gives quotient 0x8000_0000, remainder 0 (no trap).
  - Partial remainder is DATA_W+1 bits to hold the trial borrow.
- cancel_i in any state: next state IDLE, counter 0. Result registers are left unchanged (don't-care). cancel_i has priority over start_i in the same cycle.
- start_i dropping while BUSY (not via cancel_i) is illegal; an assertion flags it.
- Reset asserted mid-division: asynchronous return to reset values; no partial result is ever presented.

Decomposition:
- Shared package (cpu_pkg):
  - div_state_t enum {DIV_IDLE, DIV_BUSY, DIV_DONE}
  - DIV_ZERO_QUO = 32'hFFFF_FFFF
  - DATA_W default
- Sub-module div_step: combinational single restoring iteration. It takes {rem, quo} and the divisor and returns the next {rem, quo}, so it can be unit-tested and later doubled for radix-4.
- The FSM, counter and sign logic stay in div_unit.

Test Plan:
- DIVU 100 / 7, start_i held → ok_o = 0 for cycles 0..32. Cycle 33: ok_o = 1, quotient 14, remainder 2. Cycle 34: IDLE.
- DIV −7 / 2 (0xFFFF_FFF9 / 2) → quotient 0xFFFF_FFFD (−3), remainder 0xFFFF_FFFF (−1). Also DIV 7 / −2 → quotient −3, remainder 1.
- DIV 0x8000_0000 / 0xFFFF_FFFF → quotient 0x8000_0000, remainder 0. DIVU of the same operands → quotient 0, remainder 0x8000_0000.
- Divisor 0, dividend 0x1234 → DONE after 1 cycle, quotient 0xFFFF_FFFF, remainder 0x1234.
- cancel_i at BUSY cycle 10 → ok_o = 1 in that cycle, IDLE next. A new start_i with 9 / 3 then completes normally after 33 cycles with quotient 3, remainder 0.
- Two back-to-back DIVU (50/5, then 51/5): DONE→IDLE→BUSY. Results are 10 r0, then 10 r1. ok_o is high for exactly one cycle between the two stalls.
- resetn pulsed low at BUSY cycle 20 → outputs return to reset values immediately and state is IDLE.
